systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Transmit side of the PE array's operand interface.
- Accepts one k-step beat per handshake: one A column element per row lane and one B row element per column lane.
- Skews lane r by r steps and drives the array's a/b operand inputs and the a/b reset inputs.
- Generates the array step enable, the PE i_valid, so that stalls freeze the whole array coherently. It also inserts the reset beat and the zero drain steps that bring every PE to its finish state.

Parameters:
- DIMENSION, 4, array side (lanes per operand); also the beats per matrix.
- I_BITS, 8, operand width per lane, signed.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_s_valid  in  1  source beat valid.
- o_s_ready  out  1  feeder accepts the beat this cycle.
- i_s_a  in  DIMENSION*I_BITS  A column for step k; lane r at [r*I_BITS +: I_BITS].
- i_s_b  in  DIMENSION*I_BITS  B row for step k; lane c at [c*I_BITS +: I_BITS].
- o_step  out  1  array step enable, drives every PE i_valid.
- o_a  out  DIMENSION*I_BITS  skewed A lanes to PE(r,0).
- o_b  out  DIMENSION*I_BITS  skewed B lanes to PE(0,c).
- o_a_reset  out  DIMENSION  skewed reset flag per A lane.
- o_b_reset  out  DIMENSION  skewed reset flag per B lane.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse: drain complete, all PEs hold o_finish=1.

Behaviour:
- Reset (i_reset=0 at a clock edge): state IDLE, beat_cnt=0, drain_cnt=0, all lane registers 0. All outputs are 0, including o_s_ready. Reset overrides everything, including mid-stream or mid-drain; no o_done is produced.
- States:
  - IDLE: o_s_ready=0. If i_s_valid=1, go to RST.
  - RST: one advance. Lane inputs are data 0 and reset flag 1 on all lanes. Go to STREAM.
  - STREAM: o_s_ready=1. Advance = i_s_valid & o_s_ready; lane inputs are i_s_a/i_s_b with reset flag 0. beat_cnt increments mod DIMENSION on each advance.
    - With beat_cnt!=0 and i_s_valid=0: stall, no advance, stay in STREAM.
    - With beat_cnt==0 (matrix boundary) and i_s_valid=0: go to DRAIN with drain_cnt=0.
    - A beat presented at the boundary in the same cycle continues the stream. There is no reset and no drain; the PEs wrap their counters.
  - DRAIN: o_s_ready=0. Advance every cycle with zero data and reset flag 0. After 2*(DIMENSION-1) advances, go to IDLE and pulse o_done on the following cycle.
- Lane r (A and B alike) is a shift line of r+1 registers carrying {reset_flag, data}. It shifts only on advance; the last stage drives o_a/o_a_reset (o_b/o_b_reset) lane r.
- o_step is the advance signal registered one clock. Each array step therefore consumes exactly one fresh shift, and the relative skew between lane r and lane 0 is r steps.
- Data for lane r, beat k appears on the array step numbered 1+k+r, counting the RST step as step 0. The reset flag on lane r appears on step r.
- Between advances, all outputs hold their values; o_step=0.
- Data passes through unmodified (signed, I_BITS). There is no arithmetic in the datapath.
- Counters:
  - beat_cnt has width clog2(DIMENSION).
  - drain_cnt has width clog2(2*DIMENSION). It saturates at the terminal value and clears on entry to DRAIN.

Optional Feature:
- FEEDER_STALL_CNT_EN defined:
  - Adds output o_stall_cnt [15:0].
  - Counts cycles in STREAM with beat_cnt!=0 and i_s_valid=0, saturating at 16'hFFFF.
  - Clears in RST and on reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset with DIMENSION=4, I_BITS=8: i_reset=0 for 3 cycles with i_s_valid=1 -> all outputs 0, o_s_ready=0, o_busy=0. After release, RST is entered on the next cycle.
- Single matrix, 4 back-to-back beats with lane r of beat k = 8'h10*k+r -> o_step asserted 11 times: 1 RST + 4 data + 6 drain. o_a_reset lane r is high only on step r. o_a lane 2 carries 8'h12 on step 4. o_done pulses once, one cycle after the last o_step.
- Mid-matrix stall: i_s_valid low for 3 cycles after beat 1 -> o_step low for exactly 3 cycles, o_a/o_b unchanged, no DRAIN entry. Remaining beats are accepted normally.
- Two matrices, 8 continuous beats -> a single RST and a single 6-step drain, 15 o_step pulses total. The reset flags are never high after step 3; one o_done.
- Gap at the matrix boundary: 4 beats, idle 10 cycles, then 4 beats -> two complete sequences, each RST+4+6, and two o_done pulses. The second job starts with reset flags.
- i_reset=0 during DRAIN step 3 -> next cycle IDLE with outputs 0; no o_done pulse. With FEEDER_STALL_CNT_EN defined, o_stall_cnt=0.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Source beat handshake into systolic_feeder: one A column and one B row per accepted beat.
interface systolic_feeder_if #(
    parameter int DIMENSION = 4,
    parameter int I_BITS    = 8
);
    logic                        valid;
    logic                        ready;
    logic [DIMENSION*I_BITS-1:0] a;
    logic [DIMENSION*I_BITS-1:0] b;

    modport master (output valid, output a, output b, input ready);
    modport slave  (input valid, input a, input b, output ready);
endinterface

// File: rtl/systolic_feeder.sv
// Operand feeder for a DIMENSION x DIMENSION PE array: reset beat, skewed data lanes, drain, done.
// Optional FEEDER_STALL_CNT_EN adds o_stall_cnt (mid-matrix stall cycles, saturating).
module systolic_feeder #(
    parameter int DIMENSION = 4,
    parameter int I_BITS    = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    systolic_feeder_if.slave            s,
    output logic                        o_step,
    output logic [DIMENSION*I_BITS-1:0] o_a,
    output logic [DIMENSION*I_BITS-1:0] o_b,
    output logic [DIMENSION-1:0]        o_a_reset,
    output logic [DIMENSION-1:0]        o_b_reset,
    output logic                        o_busy,
`ifdef FEEDER_STALL_CNT_EN
    output logic [15:0]                 o_stall_cnt,
`endif
    output logic                        o_done
);
    localparam int BEAT_W  = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
    localparam int DRAIN_W = $clog2(2 * DIMENSION);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(DIMENSION - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * (DIMENSION - 1));
    localparam logic [DRAIN_W-1:0] DRAIN_FIN  = DRAIN_W'(2 * (DIMENSION - 1) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RST, ST_STREAM, ST_DRAIN} state_t;

    state_t               state_reg;
    logic [BEAT_W-1:0]    beat_cnt_reg;
    logic [DRAIN_W-1:0]   drain_cnt_reg;
    logic                 step_reg;
    logic                 done_arm_reg;
    logic                 done_reg;

    logic                 advance;
    logic                 head_rst;
    logic                 head_use_src;

    // Decides whether the lanes shift this cycle and what enters their head stage.
    always_comb begin
        advance      = 1'b0;
        head_rst     = 1'b0;
        head_use_src = 1'b0;
        case (state_reg)
            ST_RST: begin
                advance  = 1'b1;
                head_rst = 1'b1;
            end
            ST_STREAM: begin
                advance      = s.valid;
                head_use_src = 1'b1;
            end
            ST_DRAIN: advance = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_reg     <= ST_IDLE;
            beat_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            step_reg      <= 1'b0;
            done_arm_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            step_reg     <= advance;
            done_reg     <= done_arm_reg;
            done_arm_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (s.valid) state_reg <= ST_RST;
                end
                ST_RST: begin
                    beat_cnt_reg <= '0;
                    state_reg    <= ST_STREAM;
                end
                ST_STREAM: begin
                    // A beat at the matrix boundary keeps streaming; only an empty boundary drains.
                    if (s.valid) begin
                        beat_cnt_reg <= (beat_cnt_reg == BEAT_LAST) ? '0 : beat_cnt_reg + 1'b1;
                    end else if (beat_cnt_reg == '0) begin
                        drain_cnt_reg <= '0;
                        state_reg     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_reg != DRAIN_LAST) drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    if (drain_cnt_reg == DRAIN_FIN) begin
                        state_reg    <= ST_IDLE;
                        done_arm_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign s.ready = (state_reg == ST_STREAM);
    assign o_busy  = (state_reg != ST_IDLE);
    assign o_step  = step_reg;
    assign o_done  = done_reg;

    // Lane gi is gi+1 stages deep, giving the diagonal skew the array needs.
    genvar gi;
    generate
        for (gi = 0; gi < DIMENSION; gi++) begin : g_lane
            logic [I_BITS:0] a_line_reg [0:gi];
            logic [I_BITS:0] b_line_reg [0:gi];
            logic [I_BITS:0] a_head;
            logic [I_BITS:0] b_head;

            assign a_head = head_use_src ? {1'b0, s.a[gi*I_BITS +: I_BITS]} : {head_rst, {I_BITS{1'b0}}};
            assign b_head = head_use_src ? {1'b0, s.b[gi*I_BITS +: I_BITS]} : {head_rst, {I_BITS{1'b0}}};

            always_ff @(posedge i_clock) begin
                if (!i_reset) begin
                    for (int j = 0; j <= gi; j++) begin
                        a_line_reg[j] <= '0;
                        b_line_reg[j] <= '0;
                    end
                end else if (advance) begin
                    a_line_reg[0] <= a_head;
                    b_line_reg[0] <= b_head;
                    for (int j = 1; j <= gi; j++) begin
                        a_line_reg[j] <= a_line_reg[j-1];
                        b_line_reg[j] <= b_line_reg[j-1];
                    end
                end
            end

            assign o_a[gi*I_BITS +: I_BITS] = a_line_reg[gi][I_BITS-1:0];
            assign o_b[gi*I_BITS +: I_BITS] = b_line_reg[gi][I_BITS-1:0];
            assign o_a_reset[gi]            = a_line_reg[gi][I_BITS];
            assign o_b_reset[gi]            = b_line_reg[gi][I_BITS];
        end
    endgenerate

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge i_clock) begin
        if (!i_reset || state_reg == ST_RST) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == ST_STREAM && beat_cnt_reg != '0 && !s.valid
                     && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus queues expected array steps, a monitor checks each o_step.
module tb_systolic_feeder;
    localparam int D = 4;
    localparam int W = 8;

    typedef struct packed {
        logic         last;
        logic [D-1:0] ar;
        logic [D-1:0] br;
        logic [D*W-1:0] a;
        logic [D*W-1:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_feeder_if #(.DIMENSION(D), .I_BITS(W)) s_if ();

    logic           o_step, o_busy, o_done;
    logic [D*W-1:0] o_a, o_b;
    logic [D-1:0]   o_a_reset, o_b_reset;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]    o_stall_cnt;
`endif

    systolic_feeder #(.DIMENSION(D), .I_BITS(W)) dut (
        .i_clock   (clk),
        .i_reset   (rst_n),
        .s         (s_if),
        .o_step    (o_step),
        .o_a       (o_a),
        .o_b       (o_b),
        .o_a_reset (o_a_reset),
        .o_b_reset (o_b_reset),
        .o_busy    (o_busy),
`ifdef FEEDER_STALL_CNT_EN
        .o_stall_cnt (o_stall_cnt),
`endif
        .o_done    (o_done)
    );

    int total = 0;
    int bad = 0;
    int step_cnt = 0;
    int done_cnt = 0;
    exp_t exp_q[$];
    logic [D*W-1:0] log_a  [0:127];
    logic [D-1:0]   log_ar [0:127];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Step s of a job: lane r shows its reset flag on step r and beat k on step 1+k+r.
    task automatic push_job(input int n, input int base);
        int nsteps;
        exp_t e;
        nsteps = 1 + n + 2 * (D - 1);
        for (int s = 0; s < nsteps; s++) begin
            e = '0;
            for (int r = 0; r < D; r++) begin
                int k;
                k = s - 1 - r;
                e.ar[r] = (s == r);
                e.br[r] = (s == r);
                if (k >= 0 && k < n) begin
                    e.a[r*W +: W] = W'(base + 16 * k + r);
                    e.b[r*W +: W] = W'(base + 'h40 + 16 * k + r);
                end
            end
            e.last = (s == nsteps - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int base, input int k);
        logic got;
        logic ok;
        ok = 1'b0;
        for (int r = 0; r < D; r++) begin
            s_if.a[r*W +: W] = W'(base + 16 * k + r);
            s_if.b[r*W +: W] = W'(base + 'h40 + 16 * k + r);
        end
        s_if.valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            got = s_if.ready;
            tick();
            ok = got;
        end
        chk("beat_accept", ok, 1'b1);
        $display("beat base=%0h k=%0d accepted=%0b", base, k, ok);
    endtask

    task automatic idle(input int n);
        s_if.valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        s_if.valid = 1'b0;
        while (done_cnt < target && t < 200) begin
            tick();
            t++;
        end
        chk("done_seen", done_cnt, target);
    endtask

    // Monitor: every presented step pops one expectation; o_done must follow a job's final step.
    initial begin : monitor
        exp_t e;
        logic done_expect;
        done_expect = 1'b0;
        forever begin
            @(negedge clk);
            if (done_expect || o_done === 1'b1) chk("done_pulse", o_done, done_expect);
            if (o_done === 1'b1) done_cnt++;
            done_expect = 1'b0;
            if (o_step === 1'b1) begin
                if (step_cnt < 128) begin
                    log_a[step_cnt]  = o_a;
                    log_ar[step_cnt] = o_a_reset;
                end
                step_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_step", o_step, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("step_lanes", {o_a_reset, o_b_reset, o_a, o_b}, {e.ar, e.br, e.a, e.b});
                    $display("step %0d a=%0h b=%0h ar=%0b br=%0b", step_cnt - 1, o_a, o_b, o_a_reset, o_b_reset);
                    done_expect = e.last;
                end
            end
        end
    end

    initial begin : stimulus
        int base_step;
        int done_base;
        int t;
        logic [D*W-1:0] hold_a, hold_b;
        logic [D-1:0] onehot;

        rst_n = 1'b0;
        s_if.valid = 1'b1;
        s_if.a = '0;
        s_if.b = '0;

        // Reset held with valid high: everything stays quiet.
        repeat (3) begin
            tick();
            chk("reset_outputs_zero",
                {o_step, o_a, o_b, o_a_reset, o_b_reset, o_busy, o_done, s_if.ready}, '0);
        end

        // Single matrix, back-to-back beats.
        push_job(4, 'h00);
        base_step = step_cnt;
        done_base = done_cnt;
        rst_n = 1'b1;
        tick();
        chk("rst_entered", {o_busy, s_if.ready}, 2'b10);
        for (int k = 0; k < 4; k++) send_beat('h00, k);
        wait_done(done_base + 1);
        chk("single_step_count", step_cnt - base_step, 11);
        chk("single_queue_empty", exp_q.size(), 0);
        chk("single_a_lane2_step4", log_a[base_step + 4][2*W +: W], 8'h12);
        chk("single_a_lane3_step7", log_a[base_step + 7][3*W +: W], 8'h33);
        onehot = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            chk("single_a_reset_step", log_ar[base_step + s], onehot);
            onehot = onehot << 1;
        end
        chk("single_a_reset_step4", log_ar[base_step + 4], 4'b0000);

        // Mid-matrix stall after beat 1.
        push_job(4, 'h03);
        base_step = step_cnt;
        done_base = done_cnt;
        send_beat('h03, 0);
        send_beat('h03, 1);
        hold_a = o_a;
        hold_b = o_b;
        s_if.valid = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_hold", {o_step, s_if.ready, o_a, o_b}, {1'b0, 1'b1, hold_a, hold_b});
        end
        send_beat('h03, 2);
        send_beat('h03, 3);
        wait_done(done_base + 1);
        chk("stall_step_count", step_cnt - base_step, 11);
        chk("stall_queue_empty", exp_q.size(), 0);
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cnt_value", o_stall_cnt, 16'd3);
`endif

        // Two matrices streamed continuously: one reset beat, one drain.
        push_job(8, 'h40);
        base_step = step_cnt;
        done_base = done_cnt;
        for (int k = 0; k < 8; k++) send_beat('h40, k);
        wait_done(done_base + 1);
        chk("two_mat_step_count", step_cnt - base_step, 15);
        chk("two_mat_queue_empty", exp_q.size(), 0);
        chk("two_mat_done_count", done_cnt - done_base, 1);

        // Gap at the boundary: two separate jobs.
        push_job(4, 'h20);
        base_step = step_cnt;
        done_base = done_cnt;
        for (int k = 0; k < 4; k++) send_beat('h20, k);
        idle(10);
        push_job(4, 'h60);
        for (int k = 0; k < 4; k++) send_beat('h60, k);
        wait_done(done_base + 2);
        chk("gap_step_count", step_cnt - base_step, 22);
        chk("gap_queue_empty", exp_q.size(), 0);
        chk("gap_second_reset_flags", log_ar[base_step + 11], 4'b0001);

        // Reset during drain step 3.
        push_job(4, 'h11);
        base_step = step_cnt;
        done_base = done_cnt;
        for (int k = 0; k < 4; k++) send_beat('h11, k);
        s_if.valid = 1'b0;
        t = 0;
        while (step_cnt < base_step + 8 && t < 100) begin
            tick();
            t++;
        end
        chk("drain_reached", step_cnt >= base_step + 8, 1'b1);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        chk("midreset_outputs_zero",
            {o_step, o_a, o_b, o_a_reset, o_b_reset, o_busy, o_done, s_if.ready}, '0);
`ifdef FEEDER_STALL_CNT_EN
        chk("midreset_stall_cnt", o_stall_cnt, 16'd0);
`endif
        rst_n = 1'b1;
        idle(12);
        chk("midreset_no_done", done_cnt, done_base);
        chk("midreset_idle", {o_busy, o_step}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
